// File: rtl/encode_posit_8_bits_pkg.sv
// Shared constants for the 8-bit, es=0 posit encoder: decoded-word layout,
// special bit patterns and the regime bias.
package encode_posit_8_bits_pkg;

  localparam int DEC_W      = 12;
  localparam int POSIT_W    = 8;

  localparam int INF_BIT    = 11;
  localparam int ZERO_BIT   = 10;
  localparam int SIGN_BIT   = 9;
  localparam int REGIME_LSB = 5;
  localparam int REGIME_W   = 4;
  localparam int FRAC_LSB   = 0;
  localparam int FRAC_W     = 5;

  localparam logic [POSIT_W-1:0] POSIT_NAR  = 8'h80;
  localparam logic [POSIT_W-1:0] POSIT_ZERO = 8'h00;

  localparam logic [REGIME_W-1:0] REGIME_BIAS = 4'd7;
  localparam logic [REGIME_W-1:0] MAX_REGIME  = 4'd13;

endpackage

// File: rtl/set_posit_regime_run_8_bits.sv
// Maps a biased regime and sign onto the raw regime run: run length r,
// run bit b6, and an illegal flag for regimes outside 0..13.
module set_posit_regime_run_8_bits
  import encode_posit_8_bits_pkg::*;
(
  input  logic [3:0] regime,
  input  logic       sign,
  output logic [2:0] r,
  output logic       b6,
  output logic       illegal
);

  always_comb begin
    r       = 3'd7;
    b6      = 1'b0;
    illegal = 1'b0;
    if (regime > MAX_REGIME) begin
      illegal = 1'b1;
    end else if (regime >= REGIME_BIAS) begin
      // r = 7 - (R - 7) = 14 - R, which is 6 - R[2:0] in 3-bit wraparound
      b6 = sign;
      r  = 3'd6 - regime[2:0];
    end else begin
      b6 = ~sign;
      r  = 3'd7 - regime[2:0];
    end
  end

endmodule

// File: rtl/encode_posit_8_bits.sv
// Two-stage encoder from decoded posit fields to the raw 8-bit pattern,
// with a single global stall shared by both stages.
module encode_posit_8_bits
  import encode_posit_8_bits_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [DEC_W-1:0]    in_decoded,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [POSIT_W-1:0]  out_posit,
  output logic                out_error,
  output logic                out_valid,
  input  logic                out_ready
);

  logic       advance;
  logic       run_illegal;
  logic       run_b6;
  logic [2:0] run_r;

  logic       dec_inf;
  logic       dec_zero;
  logic       dec_sign;
  logic       dec_error;

  logic              s1_valid;
  logic              s1_nar;
  logic              s1_zero;
  logic              s1_sign;
  logic [FRAC_W-1:0] s1_frac;
  logic [2:0]        s1_r;
  logic              s1_b6;
  logic              s1_err;

  logic [6:0]         regime_bits;
  logic [6:0]         term_bits;
  logic [6:0]         frac_bits;
  logic [POSIT_W-1:0] assembled;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  assign dec_inf  = in_decoded[INF_BIT];
  assign dec_zero = in_decoded[ZERO_BIT];
  assign dec_sign = in_decoded[SIGN_BIT];

  set_posit_regime_run_8_bits u_regime_run (
    .regime  (in_decoded[REGIME_LSB +: REGIME_W]),
    .sign    (dec_sign),
    .r       (run_r),
    .b6      (run_b6),
    .illegal (run_illegal)
  );

  // A full-length run of zeros collapses onto 0x00/0x80, which is not a legal ordinary value
  assign dec_error = (dec_inf & dec_zero) |
                     (~dec_inf & ~dec_zero & (run_illegal | ((run_r == 3'd7) & ~run_b6)));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_nar   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_frac  <= '0;
      s1_r     <= '0;
      s1_b6    <= 1'b0;
      s1_err   <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_nar   <= dec_inf | (~dec_zero & run_illegal);
      s1_zero  <= dec_zero & ~dec_inf;
      s1_sign  <= dec_sign;
      s1_frac  <= in_decoded[FRAC_LSB +: FRAC_W];
      s1_r     <= run_r;
      s1_b6    <= run_b6;
      s1_err   <= dec_error;
    end
  end

  // Body bits 6..0: r copies of b6, the terminator (absent when r=7), then the fraction MSBs
  always_comb begin
    regime_bits = s1_b6 ? ~(7'h7F >> s1_r) : 7'h00;
    term_bits   = s1_b6 ? 7'h00 : (7'h40 >> s1_r);
    frac_bits   = {2'b00, s1_frac} >> (s1_r - 3'd1);
    assembled   = {s1_sign, regime_bits | term_bits | frac_bits};
    if (s1_nar) begin
      assembled = POSIT_NAR;
    end else if (s1_zero) begin
      assembled = POSIT_ZERO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_posit <= '0;
      out_error <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_posit <= assembled;
      out_error <= s1_err;
    end
  end

endmodule

// File: doc/encode_posit_8_bits.md
ENCODE_POSIT_8_BITS -- requirements
Module: encode_posit_8_bits

Interface
REQ-001 The block SHALL have no parameters; the posit width is fixed at 8 bits with es = 0.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_decoded  input  12  decoded posit {inf, zero, sign, regime[3:0], fraction[4:0]}, bits [11:0] in that order.
REQ-005 in_valid  input  1  in_decoded is valid this cycle.
REQ-006 in_ready  output  1  block accepts in_decoded this cycle.
REQ-007 out_posit  output  8  encoded raw posit bit pattern.
REQ-008 out_error  output  1  the word in flight was illegal; qualified by out_valid.
REQ-009 out_valid  output  1  out_posit and out_error are valid.
REQ-010 out_ready  input  1  consumer accepts the output this cycle.

Function
REQ-011 A transfer SHALL occur on each port when valid and ready are both high at a rising edge; valid SHALL NOT depend combinationally on ready.
REQ-012 The pipeline SHALL be two register stages, giving 2-cycle latency from input transfer to out_valid with no stall.
REQ-013 Stage 1 SHALL register the fields plus the derived run length r, run bit b6 and error flag; stage 2 SHALL register the assembled posit.
REQ-014 A global stall SHALL apply: advance = ~out_valid | out_ready; in_ready = advance; both stages hold while advance is low.
REQ-015 Sustained throughput SHALL be one word per cycle while out_ready stays high.
REQ-016 An output word SHALL stay stable while out_valid=1 and out_ready=0.
REQ-017 inf=1, zero=0 SHALL encode to 8'h80; zero=1, inf=0 SHALL encode to 8'h00; sign, regime and fraction are ignored in both cases.
REQ-018 inf=1 together with zero=1 SHALL set out_error and encode 8'h80.
REQ-019 For regime R in 7..13: b6 = sign and index = R-7.
REQ-020 For regime R in 0..6: b6 = ~sign and index = R.
REQ-021 Run length SHALL be r = 7 - index.
REQ-022 posit[7] SHALL equal sign.
REQ-023 posit[6 : 7-r] SHALL all equal b6.
REQ-024 When r < 7, posit[6-r] SHALL be ~b6 (terminator).
REQ-025 The remaining f = max(0, 6-r) low bits SHALL take fraction[4 : 5-f]; lower fraction bits are discarded by truncation, with no rounding.
REQ-026 The raw pattern SHALL be produced without two's-complement negation; the encoding is the exact inverse of the team decoder's raw-bit decode.
REQ-027 Regime 14 or 15 with inf=zero=0 SHALL set out_error and encode 8'h80.
REQ-028 A non-special word that encodes to 8'h00 or 8'h80 SHALL set out_error (e.g. sign=1, regime 0).

Reset
REQ-029 While rst=1 at a clock edge, both stage valid bits, out_posit, out_error and all stage data registers SHALL clear to 0.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-031 Reset mid-operation SHALL discard all in-flight words; no partial word is emitted.

Structure
REQ-032 A shared package SHALL hold: decoded-word field offsets and widths, the constants 8'h80 and 8'h00, and the regime bias 7.
REQ-033 The combinational run-length/b6 derivation SHALL be one sub-module, set_posit_regime_run_8_bits (regime, sign -> r, b6, illegal).

Verification
REQ-034 1.0: 12'h0C0 -> 8'h40, and 12'h0D0 -> 8'h50, each 2 cycles after acceptance, out_error=0.
REQ-035 Specials: 12'h400 -> 8'h00; 12'h800 -> 8'h80; 12'hC00 -> 8'h80 with out_error=1; regime 14 (12'h1C0) -> out_error=1.
REQ-036 Extremes: 12'h000 -> 8'h7F (maxpos); 12'h100 -> 8'h01 (minpos); 12'h3A0 -> 8'hC0.
REQ-037 Backpressure: stream 8 words, hold out_ready=0 for 3 cycles mid-stream -> no loss, no duplication, outputs stable, in order.
REQ-038 Exhaustive round trip: all 256 posits through the team decoder then this block -> identical bit pattern, out_error=0.
REQ-039 Reset with 2 words in flight -> out_valid=0 next cycle and neither word is ever emitted.
